alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
Control stage directly upstream of the team's 32-bit basic ALU. It accepts encoded operations over a valid/ready handshake and decodes them into the ALU's one-hot control lines: AS, sub, Shift, shift_left, bitwiseAND, bitwiseOR. The ALU shifts only one bit per pass, so for multi-bit shifts the block feeds the ALU output back as the next operand until the shift amount is exhausted. It captures the final result and cout and presents them downstream on a second valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width; must match the ALU datapath width.
SHAMT_W, 5, width of the shift-amount field taken from in_b[SHAMT_W-1:0].

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  reset, synchronous and active-high.
in_valid  input  1  upstream operation valid.
in_ready  output  1  block can accept an operation.
in_op  input  3  opcode: 000 ADD, 001 SUB, 010 SHL, 011 SHR, 100 AND, 101 OR, 110/111 illegal.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B; for shifts, in_b[SHAMT_W-1:0] is the shift amount.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_result  output  WIDTH  registered result.
out_cout  output  1  registered carry/borrow.
out_err  output  1  registered flag: the operation was illegal.
alu_A  output  WIDTH  operand A to the ALU.
alu_B  output  WIDTH  operand B to the ALU.
alu_AS, alu_sub, alu_Shift, alu_shift_left, alu_bitwiseAND, alu_bitwiseOR  output  1 each  ALU controls.
alu_Output  input  WIDTH  ALU result (combinational).
alu_cout  input  1  ALU carry out.

Behaviour:
- States: IDLE, EXEC, SHIFT, DONE. On rst, go to IDLE and clear out_result, out_cout, out_err, the latched operands and the shift counter to 0.
- in_ready = (state==IDLE) and not rst. out_valid = (state==DONE). Both are decoded from registered state only.
- IDLE: on in_valid, latch op, A, B and count = in_b[SHAMT_W-1:0].
  - ADD/SUB/AND/OR go to EXEC.
  - SHL/SHR with count==0 go to DONE with result=A, cout=0, err=0.
  - SHL/SHR with count!=0 go to SHIFT, with the working register set to A.
  - Illegal op goes to DONE with result=0, cout=0, err=1.
- EXEC (1 cycle): drive alu_A=A_lat and alu_B=B_lat.
  - Assert AS for ADD/SUB, with sub=1 for SUB.
  - Assert bitwiseAND for AND or bitwiseOR for OR.
  - Capture result=alu_Output. Capture cout=alu_cout for ADD/SUB, 0 otherwise. Go to DONE.
- SHIFT: drive alu_A=working register, alu_Shift=1, alu_shift_left=(op==SHL).
  - Each cycle: working register <= alu_Output, count <= count-1.
  - When count==1, also capture result=alu_Output, cout=0 and go to DONE.
  - An amount of N takes exactly N SHIFT cycles; maximum 31.
- DONE: hold out_result, out_cout and out_err stable while out_valid && !out_ready. On out_ready, go to IDLE. No new operation is accepted in DONE.
- ALU controls are all 0 in IDLE and DONE. At most one of AS/Shift/bitwiseAND/bitwiseOR is high in any cycle. alu_sub and alu_shift_left are 0 unless AS or Shift respectively is high.
- Arithmetic is modulo 2^WIDTH. cout is the ALU's bit WIDTH, passed through unmodified (for SUB, cout=1 when A<B unsigned).
- Latency from the accept edge to out_valid:
  - ADD/SUB/AND/OR: 2 cycles.
  - Shift by N>0: N+1 cycles.
  - Shift by 0 or illegal op: 1 cycle.
- Upper bits in_b[WIDTH-1:SHAMT_W] are ignored for shifts.
- rst asserted in any state, including mid-SHIFT, aborts the operation: next cycle is IDLE with outputs cleared and no out_valid.

Test Plan:
- ADD A=0xFFFF_FFFF, B=0x0000_0001, accepted at edge 0 -> out_valid at cycle 2, out_result=0x0000_0000, out_cout=1, out_err=0.
- SUB A=0x0000_0005, B=0x0000_0007 -> out_result=0xFFFF_FFFE, out_cout=1. Then AND 0xF0F0_F0F0 & 0xFF00_FF00 -> 0xF000_F000, cout=0.
- SHL A=0x0000_0001, B=5 -> exactly 5 cycles with alu_Shift=1 and alu_shift_left=1, out_valid at cycle 6, out_result=0x0000_0020. SHR A=0x8000_0000, B=31 -> 0x0000_0001 after 31 SHIFT cycles. SHL with B=0x0000_0020 (amount 0) -> out_result=A at cycle 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_result and out_cout stable, in_ready=0, all ALU controls 0. On out_ready=1 -> IDLE, in_ready=1 next cycle.
- Illegal op 3'b110 -> out_valid at cycle 1, out_err=1, out_result=0, and no ALU control asserted in any cycle.
- Assert rst during the 3rd SHIFT cycle of SHL by 10 -> next cycle IDLE, out_valid=0, out_result=0, in_ready=1 once rst is released. A subsequent OR 0x1 | 0x2 -> 0x3.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of the one-bit-per-pass ALU: decodes ops, iterates
// multi-bit shifts through ALU feedback, and holds the result for downstream.
module alu_op_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_err,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic             alu_AS,
    output logic             alu_sub,
    output logic             alu_Shift,
    output logic             alu_shift_left,
    output logic             alu_bitwiseAND,
    output logic             alu_bitwiseOR,
    input  logic [WIDTH-1:0] alu_Output,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SHIFT,
        DONE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    state_t               state_q, state_n;
    logic [2:0]           op_q, op_n;
    logic [WIDTH-1:0]     a_q, a_n;
    logic [WIDTH-1:0]     b_q, b_n;
    logic [WIDTH-1:0]     work_q, work_n;
    logic [SHAMT_W-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0]     res_q, res_n;
    logic                 cout_q, cout_n;
    logic                 err_q, err_n;

    logic                 in_alu_op;
    logic                 in_shift_op;
    logic                 in_zero_amt;

    assign in_alu_op   = (in_op == OP_ADD) || (in_op == OP_SUB) ||
                         (in_op == OP_AND) || (in_op == OP_OR);
    assign in_shift_op = (in_op == OP_SHL) || (in_op == OP_SHR);
    assign in_zero_amt = (in_b[SHAMT_W-1:0] == '0);

    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_cout   = cout_q;
    assign out_err    = err_q;

    always_comb begin
        state_n        = state_q;
        op_n           = op_q;
        a_n            = a_q;
        b_n            = b_q;
        work_n         = work_q;
        cnt_n          = cnt_q;
        res_n          = res_q;
        cout_n         = cout_q;
        err_n          = err_q;
        alu_A          = '0;
        alu_B          = '0;
        alu_AS         = 1'b0;
        alu_sub        = 1'b0;
        alu_Shift      = 1'b0;
        alu_shift_left = 1'b0;
        alu_bitwiseAND = 1'b0;
        alu_bitwiseOR  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_n   = in_op;
                    a_n    = in_a;
                    b_n    = in_b;
                    work_n = in_a;
                    cnt_n  = in_b[SHAMT_W-1:0];
                    res_n  = '0;
                    cout_n = 1'b0;
                    err_n  = 1'b0;
                    unique case (1'b1)
                        in_alu_op: state_n = EXEC;
                        in_shift_op && in_zero_amt: begin
                            res_n   = in_a;
                            state_n = DONE;
                        end
                        in_shift_op && !in_zero_amt: state_n = SHIFT;
                        default: begin
                            err_n   = 1'b1;
                            state_n = DONE;
                        end
                    endcase
                end
            end
            EXEC: begin
                alu_A          = a_q;
                alu_B          = b_q;
                alu_AS         = (op_q == OP_ADD) || (op_q == OP_SUB);
                alu_sub        = (op_q == OP_SUB);
                alu_bitwiseAND = (op_q == OP_AND);
                alu_bitwiseOR  = (op_q == OP_OR);
                res_n          = alu_Output;
                cout_n         = alu_AS ? alu_cout : 1'b0;
                state_n        = DONE;
            end
            SHIFT: begin
                alu_A          = work_q;
                alu_Shift      = 1'b1;
                alu_shift_left = (op_q == OP_SHL);
                work_n         = alu_Output;
                cnt_n          = cnt_q - SHAMT_W'(1);
                // Last pass: this ALU output is the final shifted value.
                if (cnt_q == SHAMT_W'(1)) begin
                    res_n   = alu_Output;
                    cout_n  = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            a_q     <= a_n;
            b_q     <= b_n;
            work_q  <= work_n;
            cnt_q   <= cnt_n;
            res_q   <= res_n;
            cout_q  <= cout_n;
            err_q   <= err_n;
        end
    end

endmodule
